uart_matrix_framer: RTL and testbench
=====================================

UART_MATRIX_FRAMER -- requirements
Module: uart_matrix_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the A/B element width in bits (8, 16, 24 or 32).
REQ-002 SHALL have parameter RESULT_WIDTH, default 8, meaning the result element width in bits (8, 16, 24 or 32).
REQ-003 SHALL have parameter MATRIX_SIZE_MIN, default 3, meaning the smallest legal N.
REQ-004 SHALL have parameter MATRIX_SIZE_MAX, default 10, meaning the largest legal N (at most 15).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the maximum number of idle clk cycles allowed between received bytes mid-frame.
REQ-006 Ports, listed as name, direction, width, meaning; AW = clog2(MATRIX_SIZE_MAX^2); one clock; reset is asynchronous and active-high:
- clk, in, 1, system clock
- reset, in, 1, async active-high reset
- rx_data, in, 8, received byte
- rx_valid, in, 1, one-cycle byte strobe (no backpressure)
- tx_data, out, 8, byte to transmit
- tx_valid, out, 1, tx_data valid
- tx_ready, in, 1, transmitter accepts the byte
- mem_we, out, 1, operand write strobe
- mem_sel, out, 1, 0 selects A, 1 selects B
- mem_addr, out, AW, row-major element index
- mem_wdata, out, DATA_WIDTH, operand element
- res_addr, out, AW, result read index
- res_rdata, in, RESULT_WIDTH, result element (1-cycle read latency)
- mm_start, out, 1, one-cycle compute start pulse
- mm_size, out, 4, N for the engine
- mm_done, in, 1, compute-complete pulse
- mm_overflow, in, 1, engine overflow (valid with mm_done)
- busy, out, 1, frame in progress
- frame_err, out, 1, one-cycle error pulse

Function
REQ-007 Frame: SOF 0xA5, size byte N, N*N A elements, N*N B elements, checksum byte; elements are DATA_WIDTH/8 bytes each, little-endian, row-major.
REQ-008 Checksum SHALL equal the XOR of every byte after SOF, up to but not including the checksum byte.
REQ-009 FSM states: IDLE, SIZE, RX_A, RX_B, CHECK, START, WAIT, TX_HDR, TX_RES, TX_ERR.
REQ-010 IDLE: ignore every byte except 0xA5; on 0xA5 go to SIZE, clear the checksum and counters.
REQ-011 SIZE: if N is outside MIN..MAX, set status bit1 and go to TX_ERR; else latch N into mm_size and go to RX_A.
REQ-012 RX_A/RX_B: assemble bytes; on the final byte of each element, pulse mem_we for 1 cycle in the cycle after that byte's rx_valid, with mem_sel, mem_addr and mem_wdata valid; after element N*N-1 advance to the next state.
REQ-013 CHECK: on the checksum byte, a mismatch sets status bit2 and goes to TX_ERR; a match goes to START.
REQ-014 START: assert mm_start for exactly 1 cycle, then go to WAIT; in WAIT latch mm_overflow into status bit0 on mm_done, then go to TX_HDR.
REQ-015 TX_HDR/TX_ERR: send status byte 0x5A ^ {4'b0, status[3:0]}; TX_ERR returns to IDLE after this byte; TX_HDR continues to TX_RES.
REQ-016 TX_RES: drive res_addr 0..N*N-1; capture res_rdata 1 cycle after the address; send RESULT_WIDTH/8 bytes per element, little-endian; return to IDLE after the last byte.
REQ-017 TX handshake: hold tx_valid and tx_data stable until a clk edge with tx_valid&&tx_ready; at most one byte transfers per cycle; tx_ready low SHALL stall indefinitely without loss.
REQ-018 Timeout: in SIZE, RX_A, RX_B or CHECK, TIMEOUT_CYCLES cycles without rx_valid SHALL set status bit3 and go to TX_ERR.
REQ-019 rx_valid in START, WAIT, TX_HDR, TX_RES or TX_ERR SHALL be ignored.
REQ-020 frame_err SHALL pulse 1 cycle on entry to TX_ERR; busy SHALL be high in every state except IDLE.
REQ-021 The status register SHALL clear on SOF acceptance.

Reset
REQ-022 While reset is high, independent of clk: state is IDLE, all outputs are 0, and counters, checksum and status are 0.
REQ-023 Reset asserted mid-frame or mid-transmit SHALL abort the frame immediately, with no further mem_we or tx_valid.

Verification
REQ-024 DATA_WIDTH=8, RESULT_WIDTH=8, N=3, A=B=identity, correct checksum, engine returns identity, no overflow -> 9 mem_we to A and 9 to B, one mm_start, TX = 0x5A then 01 00 00 00 01 00 00 00 01.
REQ-025 Size byte 0x02 -> TX 0x58, frame_err pulse, no mem_we, back to IDLE.
REQ-026 N=3 frame with checksum byte flipped -> TX 0x5E, no mm_start.
REQ-027 DATA_WIDTH=16, N=10, tx_ready toggling every other cycle, mm_overflow=1 -> status 0x5B, then 100 elements x RESULT_WIDTH/8 bytes, in order and without loss.
REQ-028 Byte stream stops after 5 A elements, TIMEOUT_CYCLES=50 -> TX 0x52 after 50 idle cycles; stray bytes then ignored until 0xA5.
REQ-029 Reset pulsed during TX_RES -> tx_valid=0 next cycle, busy=0, and a fresh frame then completes correctly.

Source files
------------

// File: rtl/uart_matrix_framer.sv
// Byte-stream framer: receives a sized A/B operand frame, loads it into the
// matrix engine, starts it, then returns a status byte followed by the result.
module uart_matrix_framer #(
  parameter int DATA_WIDTH      = 8,
  parameter int RESULT_WIDTH    = 8,
  parameter int MATRIX_SIZE_MIN = 3,
  parameter int MATRIX_SIZE_MAX = 10,
  parameter int TIMEOUT_CYCLES  = 100000,
  localparam int AW = $clog2(MATRIX_SIZE_MAX * MATRIX_SIZE_MAX)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    mem_we,
  output logic                    mem_sel,
  output logic [AW-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [AW-1:0]           res_addr,
  input  logic [RESULT_WIDTH-1:0] res_rdata,
  output logic                    mm_start,
  output logic [3:0]              mm_size,
  input  logic                    mm_done,
  input  logic                    mm_overflow,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0]    DB_LAST = 2'(DATA_WIDTH / 8 - 1);
  localparam logic [1:0]    RB_LAST = 2'(RESULT_WIDTH / 8 - 1);
  localparam logic [7:0]    N_MIN   = 8'(MATRIX_SIZE_MIN);
  localparam logic [7:0]    N_MAX   = 8'(MATRIX_SIZE_MAX);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SIZE   = 4'd1;
  localparam logic [3:0] S_RX_A   = 4'd2;
  localparam logic [3:0] S_RX_B   = 4'd3;
  localparam logic [3:0] S_CHECK  = 4'd4;
  localparam logic [3:0] S_START  = 4'd5;
  localparam logic [3:0] S_WAIT   = 4'd6;
  localparam logic [3:0] S_TX_HDR = 4'd7;
  localparam logic [3:0] S_TX_RES = 4'd8;
  localparam logic [3:0] S_TX_ERR = 4'd9;

  logic [3:0]              state_q, state_d;
  logic [3:0]              n_q, n_d;
  logic [AW-1:0]           last_q, last_d;
  logic [AW-1:0]           elem_q, elem_d;
  logic [1:0]              byte_q, byte_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [7:0]              csum_q, csum_d;
  logic [3:0]              status_q, status_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    mem_we_q, mem_we_d;
  logic                    mem_sel_q, mem_sel_d;
  logic [AW-1:0]           mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mm_start_q, mm_start_d;
  logic                    frame_err_q, frame_err_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic [AW-1:0]           res_addr_q, res_addr_d;
  logic [RESULT_WIDTH-1:0] res_word_q, res_word_d;
  logic                    rd_phase_q, rd_phase_d;

  logic       in_rx;
  logic       timeout;
  logic       go_err;
  logic [7:0] sq;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    last_d      = last_q;
    elem_d      = elem_q;
    byte_d      = byte_q;
    word_d      = word_q;
    csum_d      = csum_q;
    status_d    = status_q;
    timer_d     = timer_q;
    mem_we_d    = 1'b0;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mm_start_d  = 1'b0;
    frame_err_d = 1'b0;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    res_addr_d  = res_addr_q;
    res_word_d  = res_word_q;
    rd_phase_d  = rd_phase_q;
    timeout     = 1'b0;
    go_err      = 1'b0;
    sq          = {4'b0000, rx_data[3:0]} * {4'b0000, rx_data[3:0]};
    in_rx       = (state_q == S_SIZE) || (state_q == S_RX_A) ||
                  (state_q == S_RX_B) || (state_q == S_CHECK);

    // The idle timer restarts on every received byte while a frame is open.
    if (in_rx) begin
      if (rx_valid) begin
        timer_d = '0;
      end else if (timer_q == TO_LAST) begin
        timeout = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == 8'hA5) begin
          state_d  = S_SIZE;
          csum_d   = '0;
          elem_d   = '0;
          byte_d   = '0;
          timer_d  = '0;
          status_d = '0;
        end
      end
      S_SIZE: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
          if (rx_data < N_MIN || rx_data > N_MAX) begin
            status_d[1] = 1'b1;
            go_err      = 1'b1;
          end else begin
            n_d     = rx_data[3:0];
            last_d  = AW'(sq - 8'd1);
            state_d = S_RX_A;
          end
        end
      end
      S_RX_A, S_RX_B: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
          // Bytes shift in from the top so the first (least significant) byte ends up at bit 0.
          word_d = (word_q >> 8) | (DATA_WIDTH'(rx_data) << (DATA_WIDTH - 8));
          if (byte_q == DB_LAST) begin
            byte_d      = '0;
            mem_we_d    = 1'b1;
            mem_sel_d   = (state_q == S_RX_B);
            mem_addr_d  = elem_q;
            mem_wdata_d = word_d;
            if (elem_q == last_q) begin
              elem_d  = '0;
              state_d = (state_q == S_RX_A) ? S_RX_B : S_CHECK;
            end else begin
              elem_d = elem_q + AW'(1);
            end
          end else begin
            byte_d = byte_q + 2'd1;
          end
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          if (rx_data != csum_q) begin
            status_d[2] = 1'b1;
            go_err      = 1'b1;
          end else begin
            state_d    = S_START;
            mm_start_d = 1'b1;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (mm_done) begin
          status_d[0] = mm_overflow;
          state_d     = S_TX_HDR;
          tx_valid_d  = 1'b1;
          tx_data_d   = 8'h5A ^ {4'b0000, status_d};
        end
      end
      S_TX_HDR: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_TX_RES;
          elem_d     = '0;
          byte_d     = '0;
          res_addr_d = '0;
          rd_phase_d = 1'b0;
        end
      end
      S_TX_RES: begin
        // One bubble cycle after each new address covers the result memory's read latency.
        if (!tx_valid_q) begin
          if (!rd_phase_q) begin
            rd_phase_d = 1'b1;
          end else begin
            rd_phase_d = 1'b0;
            res_word_d = res_rdata;
            tx_data_d  = res_rdata[7:0];
            tx_valid_d = 1'b1;
            byte_d     = '0;
          end
        end else if (tx_ready) begin
          if (byte_q == RB_LAST) begin
            tx_valid_d = 1'b0;
            if (elem_q == last_q) begin
              state_d = S_IDLE;
            end else begin
              elem_d     = elem_q + AW'(1);
              res_addr_d = res_addr_q + AW'(1);
            end
          end else begin
            byte_d     = byte_q + 2'd1;
            res_word_d = res_word_q >> 8;
            tx_data_d  = res_word_d[7:0];
          end
        end
      end
      S_TX_ERR: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      status_d[3] = 1'b1;
      go_err      = 1'b1;
    end

    if (go_err) begin
      state_d     = S_TX_ERR;
      frame_err_d = 1'b1;
      tx_valid_d  = 1'b1;
      tx_data_d   = 8'h5A ^ {4'b0000, status_d};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      last_q      <= '0;
      elem_q      <= '0;
      byte_q      <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      status_q    <= '0;
      timer_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mm_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      res_addr_q  <= '0;
      res_word_q  <= '0;
      rd_phase_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      last_q      <= last_d;
      elem_q      <= elem_d;
      byte_q      <= byte_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      status_q    <= status_d;
      timer_q     <= timer_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mm_start_q  <= mm_start_d;
      frame_err_q <= frame_err_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      res_addr_q  <= res_addr_d;
      res_word_q  <= res_word_d;
      rd_phase_q  <= rd_phase_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign res_addr  = res_addr_q;
  assign mm_start  = mm_start_q;
  assign mm_size   = n_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_matrix_framer.sv
// Scoreboard bench for uart_matrix_framer: random frames, a matrix-multiply
// engine model, and queue-based checking of operand writes and TX bytes.
module tb_uart_matrix_framer;

  localparam int DW = 16;
  localparam int RW = 24;
  localparam int NMIN = 3;
  localparam int NMAX = 10;
  localparam int TO = 50;
  localparam int AW = $clog2(NMAX * NMAX);

  localparam int M_GOOD    = 0;
  localparam int M_BADCS   = 1;
  localparam int M_BADSIZE = 2;
  localparam int M_TIMEOUT = 3;

  logic          clk;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          mem_we;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] res_addr;
  logic [RW-1:0] res_rdata;
  logic          mm_start;
  logic [3:0]    mm_size;
  logic          mm_done;
  logic          mm_overflow;
  logic          busy;
  logic          frame_err;

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_exp_t;

  mem_exp_t   exp_mem[$];
  logic [7:0] exp_tx[$];

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int ferrs = 0;
  int tx_count = 0;
  int start0 = 0;
  int ferr0 = 0;
  int ready_mode = 0;
  logic ovf_cfg = 1'b0;

  logic [DW-1:0] ref_a [0:NMAX*NMAX-1];
  logic [DW-1:0] ref_b [0:NMAX*NMAX-1];
  logic [RW-1:0] res_mem [0:127];

  uart_matrix_framer #(
    .DATA_WIDTH(DW),
    .RESULT_WIDTH(RW),
    .MATRIX_SIZE_MIN(NMIN),
    .MATRIX_SIZE_MAX(NMAX),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .mem_we(mem_we),
    .mem_sel(mem_sel),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .res_addr(res_addr),
    .res_rdata(res_rdata),
    .mm_start(mm_start),
    .mm_size(mm_size),
    .mm_done(mm_done),
    .mm_overflow(mm_overflow),
    .busy(busy),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result memory with one cycle of read latency
  always @(posedge clk) res_rdata <= res_mem[res_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0h, expected nothing", name, act);
  endtask

  // Transmit-side acceptance pattern
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Engine model: answers each start pulse after a random delay
  initial begin
    mm_done = 1'b0;
    mm_overflow = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && mm_start) begin
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
        mm_done = 1'b1;
        mm_overflow = ovf_cfg;
        @(posedge clk);
        #1;
        mm_done = 1'b0;
        mm_overflow = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a write or a byte
  initial begin
    logic       hold;
    logic [7:0] held;
    mem_exp_t   e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (mem_we) begin
          if (exp_mem.size() == 0) begin
            fail_now("mem_we_unexpected", {mem_sel, mem_addr, mem_wdata});
          end else begin
            e = exp_mem.pop_front();
            chk("mem_write", {mem_sel, mem_addr, mem_wdata}, {e.sel, e.addr, e.data});
          end
        end
        if (tx_valid) begin
          if (hold) chk("tx_hold", tx_data, held);
          if (tx_ready) begin
            hold = 1'b0;
            tx_count++;
            if (exp_tx.size() == 0) fail_now("tx_unexpected", tx_data);
            else chk("tx_byte", tx_data, exp_tx.pop_front());
          end else begin
            hold = 1'b1;
            held = tx_data;
          end
        end else begin
          if (hold) fail_now("tx_valid_dropped", held);
          hold = 1'b0;
        end
        if (mm_start) starts++;
        if (frame_err) ferrs++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, max_gap)) @(posedge clk);
  endtask

  task automatic send_stray(input int count);
    logic [7:0] b;
    for (int s = 0; s < count; s++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h03;
      send_byte(b, 2);
    end
  endtask

  task automatic send_frame(input int n, input int mode, input logic ovf, input int rmode, input bit ident);
    logic [7:0]      cs;
    logic [7:0]      sz;
    logic [DW-1:0]   ev;
    logic [RW-1:0]   rv;
    longint unsigned acc;
    mem_exp_t        me;
    int              nn;
    int              na;
    int              cnt;
    ready_mode = rmode;
    ovf_cfg = ovf;
    start0 = starts;
    ferr0 = ferrs;
    sz = n[7:0];
    send_byte(8'hA5, 2);
    cs = sz;
    if (mode == M_BADSIZE) begin
      exp_tx.push_back(8'h58);
      send_byte(sz, 2);
      return;
    end
    send_byte(sz, 2);
    nn = n * n;
    for (int i = 0; i < nn; i++) begin
      ref_a[i] = ident ? DW'((i % (n + 1)) == 0) : DW'($urandom);
      ref_b[i] = ident ? DW'((i % (n + 1)) == 0) : DW'($urandom);
    end
    na = (mode == M_TIMEOUT) ? 5 : nn;
    for (int i = 0; i < na; i++) begin
      me.sel = 1'b0;
      me.addr = AW'(i);
      me.data = ref_a[i];
      exp_mem.push_back(me);
      ev = ref_a[i];
      for (int k = 0; k < DW / 8; k++) begin
        cs ^= ev[8*k +: 8];
        send_byte(ev[8*k +: 8], (mode == M_TIMEOUT && i == na - 1 && k == DW / 8 - 1) ? 0 : 2);
      end
    end
    if (mode == M_TIMEOUT) begin
      exp_tx.push_back(8'h52);
      cnt = 0;
      while (!tx_valid && cnt < 200) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      chk("timeout_latency_window", (cnt >= TO && cnt <= TO + 1), 1'b1);
      return;
    end
    for (int i = 0; i < nn; i++) begin
      me.sel = 1'b1;
      me.addr = AW'(i);
      me.data = ref_b[i];
      exp_mem.push_back(me);
      ev = ref_b[i];
      for (int k = 0; k < DW / 8; k++) begin
        cs ^= ev[8*k +: 8];
        send_byte(ev[8*k +: 8], 2);
      end
    end
    if (mode == M_BADCS) begin
      exp_tx.push_back(8'h5E);
      send_byte(~cs, 2);
    end else begin
      exp_tx.push_back(8'h5A ^ {7'b0, ovf});
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          acc = 0;
          for (int k = 0; k < n; k++)
            acc += longint'(ref_a[r*n+k]) * longint'(ref_b[k*n+c]);
          rv = acc[RW-1:0];
          res_mem[r*n+c] = rv;
          for (int k = 0; k < RW / 8; k++) exp_tx.push_back(rv[8*k +: 8]);
        end
      end
      send_byte(cs, 2);
    end
    send_stray(3);
  endtask

  task automatic finish_frame(input int mode);
    int cyc;
    cyc = 0;
    while ((exp_tx.size() != 0 || busy) && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("frame_completes", cyc < 20000, 1'b1);
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("mem_queue_drained", exp_mem.size(), 0);
    chk("mm_start_count", starts - start0, (mode == M_GOOD) ? 1 : 0);
    chk("frame_err_count", ferrs - ferr0, (mode == M_GOOD) ? 0 : 1);
    chk("idle_after_frame", busy, 1'b0);
  endtask

  task automatic run_frame(input int n, input int mode, input logic ovf, input int rmode, input bit ident);
    send_frame(n, mode, ovf, rmode, ident);
    finish_frame(mode);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int cyc;
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    for (int i = 0; i < 128; i++) res_mem[i] = '0;
    #2;
    chk("reset_tx_valid", tx_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_outputs", {tx_data, mem_we, mem_sel, mem_addr, mem_wdata, res_addr, mm_start, mm_size, frame_err}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    run_frame(3, M_GOOD, 1'b0, 0, 1'b1);
    run_frame(2, M_BADSIZE, 1'b0, 2, 1'b0);
    run_frame(11, M_BADSIZE, 1'b0, 0, 1'b0);
    run_frame(3, M_BADCS, 1'b0, 2, 1'b0);
    run_frame(10, M_GOOD, 1'b1, 1, 1'b0);
    run_frame(6, M_TIMEOUT, 1'b0, 0, 1'b0);

    send_stray(6);
    send_byte(8'h03, 2);
    repeat (4) @(posedge clk);
    #1;
    chk("stray_ignored_idle", busy, 1'b0);

    base = tx_count;
    send_frame(4, M_GOOD, 1'b0, 0, 1'b0);
    cyc = 0;
    while (tx_count < base + 5 && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("reached_tx_res", tx_count >= base + 5, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_tx_valid", tx_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_outputs", {tx_data, mem_we, res_addr, mm_start, mm_size, frame_err}, 0);
    exp_tx.delete();
    exp_mem.delete();
    repeat (2) @(negedge clk);
    chk("abort_held", {tx_valid, mem_we, busy}, 0);
    reset = 1'b0;
    run_frame(5, M_GOOD, 1'b0, 2, 1'b0);

    for (int f = 0; f < 4; f++)
      run_frame($urandom_range(NMIN, NMAX), M_GOOD, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
